// File: rtl/fpdiv_sp_stream_ctrl_if.sv
// Stream-side bundle for fpdiv_sp_stream_ctrl: operand input channel and result output channel.
// master = producer/consumer of the streams, slave = the controller.
interface fpdiv_sp_stream_ctrl_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [33:0]      in_x;
  logic [33:0]      in_y;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [33:0]      out_r;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_exn;

  modport master (
    output in_valid, in_x, in_y, in_tag, out_ready,
    input  in_ready, out_valid, out_r, out_tag, out_exn
  );

  modport slave (
    input  in_valid, in_x, in_y, in_tag, out_ready,
    output in_ready, out_valid, out_r, out_tag, out_exn
  );
endinterface

// File: rtl/fpdiv_sp_stream_ctrl.sv
// Valid/ready front-end and FWFT result FIFO around a fixed-latency, clock-enable-only
// FloPoCo single-precision divider; a credit counter keeps the FIFO from overflowing.
module fpdiv_sp_stream_ctrl #(
  parameter int NUM_STAGES = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int TAG_W      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fpdiv_sp_stream_ctrl_if.slave  strm,
  output logic                   div_ce,
  output logic [33:0]            div_x,
  output logic [33:0]            div_y,
  input  logic [33:0]            div_r,
  output logic                   busy
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]      reserved;
  logic [NUM_STAGES-1:0] vsr;
  logic [TAG_W-1:0]      tsr [NUM_STAGES];

  logic [33:0]           fifo_r   [FIFO_DEPTH];
  logic [TAG_W-1:0]      fifo_tag [FIFO_DEPTH];
  logic [PTR_W:0]        wr_ptr;
  logic [PTR_W:0]        rd_ptr;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      rd_idx;

  logic issue;
  logic pop;
  logic fifo_wr;
  logic empty;
  logic full;

  // reserved counts every op that will eventually occupy a FIFO slot, so gating
  // acceptance on it alone is enough to guarantee a free slot at write time.
  assign strm.in_ready = rst_n && (reserved < DEPTH_C);
  assign issue         = strm.in_valid && strm.in_ready;
  assign div_ce        = issue || (|vsr);
  assign div_x         = strm.in_x;
  assign div_y         = strm.in_y;
  assign fifo_wr       = div_ce && vsr[NUM_STAGES-1];
  assign busy          = (reserved != '0);

  assign wr_idx  = wr_ptr[PTR_W-1:0];
  assign rd_idx  = rd_ptr[PTR_W-1:0];
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign pop     = strm.out_valid && strm.out_ready;

  assign strm.out_valid = !empty;
  assign strm.out_r     = empty ? '0 : fifo_r[rd_idx];
  assign strm.out_tag   = empty ? '0 : fifo_tag[rd_idx];
  assign strm.out_exn   = strm.out_r[33:32];

  // Shadow of the divider pipeline: advances in lockstep with div_ce so that
  // vsr[NUM_STAGES-1] marks the cycle in which div_r carries a real result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr <= '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
        tsr[i] <= '0;
      end
    end else if (div_ce) begin
      vsr[0] <= issue;
      tsr[0] <= strm.in_tag;
      for (int i = 1; i < NUM_STAGES; i++) begin
        vsr[i] <= vsr[i-1];
        tsr[i] <= tsr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reserved <= '0;
    end else begin
      case ({issue, pop})
        2'b10:   reserved <= reserved + CNT_W'(1);
        2'b01:   reserved <= reserved - CNT_W'(1);
        default: reserved <= reserved;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_wr) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_r[wr_idx]   <= div_r;
      fifo_tag[wr_idx] <= tsr[NUM_STAGES-1];
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      a_no_write_full: assert (!(fifo_wr && full));
      a_no_pop_empty:  assert (!(pop && empty));
      a_credit_bound:  assert (reserved <= DEPTH_C);
    end
  end
endmodule

// File: tb/tb_fpdiv_sp_stream_ctrl.sv
// Bench for fpdiv_sp_stream_ctrl: a behavioural FloPoCo divider pipeline, directed vector
// table, then streaming, backpressure, full-FIFO pop/accept and mid-flight reset sequences.
module tb_fpdiv_sp_stream_ctrl;
  localparam int NUM_STAGES = 12;
  localparam int FIFO_DEPTH = 16;
  localparam int TAG_W      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        div_ce;
  logic        busy;
  logic [33:0] div_x;
  logic [33:0] div_y;
  logic [33:0] div_r;

  fpdiv_sp_stream_ctrl_if #(.TAG_W(TAG_W)) bus ();

  fpdiv_sp_stream_ctrl #(
    .NUM_STAGES(NUM_STAGES),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .strm(bus),
    .div_ce(div_ce),
    .div_x(div_x),
    .div_y(div_y),
    .div_r(div_r),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference quotient for FloPoCo sp operands, round-to-nearest-even on normals.
  function automatic logic [33:0] fp_div(input logic [33:0] a, input logic [33:0] b);
    logic [1:0]  ea;
    logic [1:0]  eb;
    logic        s;
    logic [49:0] num;
    logic [49:0] den;
    logic [49:0] q;
    logic [49:0] rem;
    logic [23:0] m;
    logic        g;
    logic        st;
    int          e;
    ea = a[33:32];
    eb = b[33:32];
    s  = a[31] ^ b[31];
    if (ea == 2'b11 || eb == 2'b11 || (ea == 2'b00 && eb == 2'b00) || (ea == 2'b10 && eb == 2'b10))
      return {2'b11, 32'b0};
    if (ea == 2'b10 || eb == 2'b00)
      return {2'b10, s, 31'b0};
    if (ea == 2'b00 || eb == 2'b10)
      return {2'b00, s, 31'b0};
    num = {26'b0, 1'b1, a[22:0]} << 25;
    den = {26'b0, 1'b1, b[22:0]};
    q   = num / den;
    rem = num % den;
    if (q[25]) begin
      e  = int'(a[30:23]) - int'(b[30:23]) + 127;
      m  = q[25:2];
      g  = q[1];
      st = q[0] | (rem != 0);
    end else begin
      e  = int'(a[30:23]) - int'(b[30:23]) + 126;
      m  = q[24:1];
      g  = q[0];
      st = (rem != 0);
    end
    if (g && (st || m[0])) begin
      m = m + 24'd1;
      if (m == 24'd0) begin
        m = 24'h800000;
        e = e + 1;
      end
    end
    return {2'b01, s, 8'(e), m[22:0]};
  endfunction

  // Behavioural divider: clock-enable only, fixed NUM_STAGES latency, no reset.
  logic [33:0] pipe [NUM_STAGES];
  always @(posedge clk) begin
    if (div_ce) begin
      pipe[0] <= fp_div(div_x, div_y);
      for (int i = 1; i < NUM_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign div_r = pipe[NUM_STAGES-1];

  typedef struct packed {
    logic [33:0]      r;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct {
    logic [33:0]      x;
    logic [33:0]      y;
    logic [TAG_W-1:0] tag;
    logic [33:0]      r;
    logic [1:0]       exn;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_tx  = 0;
  int   n_rx  = 0;
  int   idx   = 0;
  res_t exp_q[$];
  res_t cur_exp;
  vec_t vecs[7];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [33:0] x, input logic [33:0] y,
                                input logic [TAG_W-1:0] tag, input logic [33:0] r);
    bus.in_valid = v;
    bus.in_x     = x;
    bus.in_y     = y;
    bus.in_tag   = tag;
    cur_exp.r    = r;
    cur_exp.tag  = tag;
  endtask

  // One clock: score a pop, record an accept, then advance to posedge+1.
  task automatic step();
    res_t e;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_output("sb_out_r", bus.out_r, e.r);
        check_output("sb_out_tag", bus.out_tag, e.tag);
        check_output("sb_out_exn", bus.out_exn, e.r[33:32]);
      end
      n_rx++;
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(cur_exp);
      n_tx++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic op_bp(input int k);
    logic [22:0] f;
    f = 23'(k * 4099 + 17);
    apply_stimulus(1'b1, {2'b01, 1'b0, 8'd130, f}, 34'h1_40000000, TAG_W'(k),
                   {2'b01, 1'b0, 8'd129, f});
  endtask

  task automatic op_rand(input int k);
    logic        sx;
    logic        sy;
    logic [7:0]  ex;
    logic [7:0]  ey;
    logic [22:0] fx;
    sx = 1'($urandom_range(1, 0));
    sy = 1'($urandom_range(1, 0));
    ex = 8'($urandom_range(150, 100));
    ey = 8'($urandom_range(134, 120));
    fx = 23'($urandom);
    apply_stimulus(1'b1, {2'b01, sx, ex, fx}, {2'b01, sy, ey, 23'b0}, TAG_W'(k),
                   {2'b01, sx ^ sy, 8'(ex - ey + 8'd127), fx});
  endtask

  task automatic run_steps(input int n, input int last);
    int txb;
    for (int c = 0; c < n; c++) begin
      txb = n_tx;
      step();
      if (n_tx != txb) begin
        idx++;
        if (idx < last) op_bp(idx);
        else bus.in_valid = 1'b0;
      end
    end
  endtask

  task automatic issue_one(input string name, input logic [33:0] x, input logic [33:0] y,
                           input logic [TAG_W-1:0] tag, input logic [33:0] r, input logic [1:0] exn);
    int lat;
    bus.out_ready = 1'b0;
    check_output({name, "_in_ready"}, bus.in_ready, 1);
    apply_stimulus(1'b1, x, y, tag, r);
    step();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      step();
      lat++;
    end
    check_output({name, "_latency"}, lat, NUM_STAGES + 1);
    check_output({name, "_out_r"}, bus.out_r, r);
    check_output({name, "_out_tag"}, bus.out_tag, tag);
    check_output({name, "_out_exn"}, bus.out_exn, exn);
    check_output({name, "_ce_idle"}, div_ce, 0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check_output({name, "_drained"}, bus.out_valid, 0);
    check_output({name, "_not_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tx0;
    int rx0;
    int txb;
    int rxb;
    int first_rx;
    int gaps;
    int not_ready;
    int seen;

    vecs[0] = '{34'h1_40C00000, 34'h1_40000000, 4'd3, 34'h1_40400000, 2'b01};
    vecs[1] = '{34'h1_3F800000, 34'h0_00000000, 4'd5, 34'h2_00000000, 2'b10};
    vecs[2] = '{34'h1_3F800000, 34'h1_40400000, 4'd6, 34'h1_3EAAAAAB, 2'b01};
    vecs[3] = '{34'h1_41000000, 34'h1_C0000000, 4'd7, 34'h1_C0800000, 2'b01};
    vecs[4] = '{34'h0_00000000, 34'h1_40A00000, 4'd8, 34'h0_00000000, 2'b00};
    vecs[5] = '{34'h2_00000000, 34'h1_40000000, 4'd9, 34'h2_00000000, 2'b10};
    vecs[6] = '{34'h3_00000000, 34'h1_3F800000, 4'd10, 34'h3_00000000, 2'b11};

    apply_stimulus(1'b0, '0, '0, '0, '0);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_in_ready", bus.in_ready, 0);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_div_ce", div_ce, 0);
    check_output("rst_out_r", bus.out_r, 0);
    check_output("rst_out_tag", bus.out_tag, 0);
    check_output("rst_out_exn", bus.out_exn, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] directed vector table");
    for (int i = 0; i < 7; i++) begin
      issue_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].r, vecs[i].exn);
    end

    $display("[TB] streaming 64 ops");
    bus.out_ready = 1'b1;
    tx0 = n_tx;
    rx0 = n_rx;
    idx = 0;
    first_rx = -1;
    gaps = 0;
    not_ready = 0;
    op_rand(0);
    for (int c = 0; c < 300 && (n_rx - rx0) < 64; c++) begin
      if (idx < 64 && !bus.in_ready) not_ready++;
      if (bus.out_valid && first_rx < 0) first_rx = c;
      if (!bus.out_valid && first_rx >= 0 && (n_rx - rx0) < 64) gaps++;
      txb = n_tx;
      step();
      if (n_tx != txb) begin
        idx++;
        if (idx < 64) op_rand(idx);
        else bus.in_valid = 1'b0;
      end
    end
    check_output("stream_accepted", n_tx - tx0, 64);
    check_output("stream_received", n_rx - rx0, 64);
    check_output("stream_in_ready_drops", not_ready, 0);
    check_output("stream_first_latency", first_rx, NUM_STAGES + 1);
    check_output("stream_gaps", gaps, 0);
    bus.out_ready = 1'b0;

    $display("[TB] backpressure 20 ops");
    tx0 = n_tx;
    rx0 = n_rx;
    idx = 0;
    op_bp(0);
    run_steps(40, 20);
    check_output("bp_accepted", n_tx - tx0, FIFO_DEPTH);
    check_output("bp_in_ready_low", bus.in_ready, 0);
    check_output("bp_out_valid", bus.out_valid, 1);
    check_output("bp_busy", busy, 1);
    check_output("bp_ce_frozen", div_ce, 0);
    bus.out_ready = 1'b1;
    run_steps(80, 20);
    check_output("bp_total_accepted", n_tx - tx0, 20);
    check_output("bp_total_received", n_rx - rx0, 20);
    check_output("bp_queue_empty", exp_q.size(), 0);
    bus.out_ready = 1'b0;

    $display("[TB] pop and accept at full");
    tx0 = n_tx;
    rx0 = n_rx;
    idx = 0;
    op_bp(0);
    run_steps(40, 40);
    check_output("full_accepted", n_tx - tx0, FIFO_DEPTH);
    txb = n_tx;
    rxb = n_rx;
    bus.out_ready = 1'b1;
    run_steps(1, 40);
    bus.out_ready = 1'b0;
    run_steps(6, 40);
    check_output("full_pulse_pops", n_rx - rxb, 1);
    check_output("full_pulse_accepts", n_tx - txb, 1);
    check_output("full_in_ready_low", bus.in_ready, 0);
    run_steps(20, 40);
    check_output("full_still_held", n_tx - txb, 1);
    check_output("full_out_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    run_steps(40, 40);
    check_output("full_drained", n_rx - rx0, FIFO_DEPTH + 1);
    check_output("full_queue_empty", exp_q.size(), 0);
    check_output("full_not_busy", busy, 0);

    $display("[TB] reset mid-flight");
    idx = 0;
    op_bp(0);
    run_steps(4, 5);
    rst_n = 1'b0;
    #1;
    check_output("midrst_out_valid", bus.out_valid, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_in_ready", bus.in_ready, 0);
    check_output("midrst_div_ce", div_ce, 0);
    exp_q.delete();
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.out_valid) seen++;
      step();
    end
    check_output("midrst_no_stale", seen, 0);
    issue_one("post_rst", 34'h1_40C00000, 34'h1_40000000, 4'd3, 34'h1_40400000, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
